sqrt2_bus_ctrl: RTL
===================

// Module: sqrt2_bus_ctrl
// PURPOSE
//  Sits directly upstream of the sqrt2 core and owns its shared inout IO_DATA bus and its ENABLE line.
//  Accepts fp16 operands on a valid/ready stream and runs one sqrt2 operation per operand:
//  drive the operand, turn the bus around, wait for RESULT, then capture the result word and the NaN/Inf flags.
//  Returns each result on a valid/ready stream. A timeout guards against a core that never answers.
// PARAMETERS
//  MIN_WAIT  2   WAIT cycles that must pass before a capture is allowed (bus turnaround margin)
//  TIMEOUT   32  WAIT cycles without SQ_RESULT before the operation is aborted; must be > MIN_WAIT
// PORTS
//  CLK          in     1   clock, all state changes on posedge
//  RESET        in     1   asynchronous, active-high reset
//  IN_DATA      in     16  fp16 operand
//  IN_VALID     in     1   operand valid
//  IN_READY     out    1   controller can accept an operand
//  OUT_DATA     out    16  captured fp16 result
//  OUT_NAN      out    1   captured IS_NAN
//  OUT_PINF     out    1   captured IS_PINF
//  OUT_NINF     out    1   captured IS_NINF
//  OUT_TIMEOUT  out    1   operation aborted by timeout
//  OUT_VALID    out    1   result valid
//  OUT_READY    in     1   consumer accepts the result
//  SQ_DATA      inout  16  to sqrt2 IO_DATA; driven only in LOAD, otherwise 16'hZZZZ
//  SQ_ENABLE    out    1   to sqrt2 ENABLE
//  SQ_RESULT    in     1   from sqrt2 RESULT
//  SQ_NAN, SQ_PINF, SQ_NINF  in  1 each  from sqrt2 IS_NAN / IS_PINF / IS_NINF
// BEHAVIOUR
//  States: IDLE, LOAD, WAIT, HOLD.
//  Reset values: state=IDLE, SQ_ENABLE=0, SQ_DATA=Z, IN_READY=1, OUT_VALID=0, all OUT_* regs=0, wait_cnt=0.
//  IDLE:
//   - IN_READY=1, SQ_ENABLE=0.
//   - On a posedge with IN_VALID=1: latch IN_DATA into op_reg and go to LOAD.
//  LOAD (exactly 1 cycle):
//   - SQ_ENABLE=1; SQ_DATA=op_reg; IN_READY=0.
//   - Next state is WAIT; wait_cnt=0.
//  WAIT:
//   - SQ_ENABLE=1; SQ_DATA=Z.
//   - wait_cnt increments each cycle (saturating 8 bit).
//   - The core starts driving the bus on the 2nd WAIT cycle. The controller never drives outside LOAD, so there is no contention.
//   - Capture on a posedge with SQ_RESULT=1 and wait_cnt>=MIN_WAIT:
//     - OUT_DATA<=SQ_DATA and OUT_NAN/PINF/NINF<=SQ_*.
//     - OUT_TIMEOUT<=0, OUT_VALID<=1, go to HOLD.
//   - Else, if wait_cnt==TIMEOUT-1: OUT_DATA<=16'h7E00, OUT_NAN/PINF/NINF<=0, OUT_TIMEOUT<=1, OUT_VALID<=1, go to HOLD.
//   - If capture and timeout coincide, capture wins.
//  HOLD:
//   - SQ_ENABLE=0, so the core clears its load/counter state on the next posedge.
//   - OUT_* held stable while OUT_VALID=1 && OUT_READY=0.
//   - On a posedge with OUT_READY=1: OUT_VALID<=0, go to IDLE.
//   - HOLD lasts >=1 cycle, which guarantees >=1 ENABLE-low posedge between operations.
//   - IN_READY=0; no operand is accepted while a result is pending.
//  Latency, accept posedge to OUT_VALID:
//   - special cases (0, NaN, negative, +Inf): MIN_WAIT+2 = 4 cycles.
//   - normal/denormal: 15 cycles with the current sqrt2 timing.
//  Throughput: one operation per latency+2 cycles with OUT_READY tied high.
//  Reset mid-operation (any state): immediately IDLE, SQ_ENABLE=0, SQ_DATA=Z, OUT_VALID=0; the in-flight result is discarded.
//  SQ_RESULT in IDLE/LOAD/HOLD is ignored. X on SQ_DATA outside a capture edge is ignored.
// TESTING
//  1. Normal: IN_DATA=16'h4400 (4.0) -> OUT_DATA=16'h4000, flags 0, OUT_VALID 15 cycles after accept.
//  2. Negative: IN_DATA=16'hC000 -> OUT_DATA=16'hFE00, OUT_NAN=1, OUT_VALID 4 cycles after accept.
//  3. Specials: 16'h7C00 -> 16'h7C00 with OUT_PINF=1; 16'h0000 -> 16'h0000 with flags 0; 16'h7C01 -> 16'h7E01 with OUT_NAN=1.
//  4. Backpressure: OUT_READY=0 for 10 cycles after OUT_VALID -> OUT_* stable, IN_READY=0, SQ_ENABLE=0; release -> IDLE the next cycle.
//  5. Timeout: stub core with RESULT stuck 0 -> OUT_TIMEOUT=1, OUT_DATA=16'h7E00 after 32 WAIT cycles.
//  6. Reset during WAIT (cycle 5), then back-to-back operands 16'h4400, 16'h3C00 -> no bus contention (checker: never two drivers), results 16'h4000, 16'h3C00.

Source files
------------

// File: rtl/sqrt2_bus_ctrl_if.sv
// sqrt2_bus_ctrl_if: operand and result valid/ready streams of the sqrt2 bus controller
interface sqrt2_bus_ctrl_if;
  logic [15:0] IN_DATA;
  logic        IN_VALID;
  logic        IN_READY;
  logic [15:0] OUT_DATA;
  logic        OUT_NAN;
  logic        OUT_PINF;
  logic        OUT_NINF;
  logic        OUT_TIMEOUT;
  logic        OUT_VALID;
  logic        OUT_READY;
  modport master (output IN_DATA, IN_VALID, OUT_READY,
                  input  IN_READY, OUT_DATA, OUT_NAN, OUT_PINF, OUT_NINF, OUT_TIMEOUT, OUT_VALID);
  modport slave  (input  IN_DATA, IN_VALID, OUT_READY,
                  output IN_READY, OUT_DATA, OUT_NAN, OUT_PINF, OUT_NINF, OUT_TIMEOUT, OUT_VALID);
endinterface

// File: rtl/sqrt2_bus_ctrl.sv
// sqrt2_bus_ctrl: sequences one sqrt2 operation per operand over the core's shared IO_DATA bus
module sqrt2_bus_ctrl #(
  parameter int MIN_WAIT = 2,
  parameter int TIMEOUT  = 32
) (
  input  logic              CLK,
  input  logic              RESET,
  sqrt2_bus_ctrl_if.slave   bus,
  inout  wire  [15:0]       SQ_DATA,
  output logic              SQ_ENABLE,
  input  logic              SQ_RESULT,
  input  logic              SQ_NAN,
  input  logic              SQ_PINF,
  input  logic              SQ_NINF
);
  typedef enum logic [1:0] {IDLE, LOAD, WAIT, HOLD} state_t;
  state_t      state_q, state_d;
  logic [15:0] op_q, op_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic [19:0] res_q, res_d;
  logic        valid_q, valid_d;
  logic        capture, expire;
  assign capture = SQ_RESULT && (wait_cnt_q >= 8'(MIN_WAIT));
  assign expire  = wait_cnt_q == 8'(TIMEOUT - 1);
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    wait_cnt_d = wait_cnt_q;
    res_d      = res_q;
    valid_d    = valid_q;
    case (state_q)
      IDLE: if (bus.IN_VALID) begin
        op_d    = bus.IN_DATA;
        state_d = LOAD;
      end
      LOAD: begin
        wait_cnt_d = '0;
        state_d    = WAIT;
      end
      WAIT: begin
        wait_cnt_d = (wait_cnt_q == 8'hFF) ? wait_cnt_q : wait_cnt_q + 8'd1;
        if (capture || expire) begin
          res_d   = capture ? {SQ_DATA, SQ_NAN, SQ_PINF, SQ_NINF, 1'b0} : {16'h7E00, 4'b0001};
          valid_d = 1'b1;
          state_d = HOLD;
        end
      end
      default: if (bus.OUT_READY) begin
        valid_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q    <= IDLE;
      op_q       <= '0;
      wait_cnt_q <= '0;
      res_q      <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      wait_cnt_q <= wait_cnt_d;
      res_q      <= res_d;
      valid_q    <= valid_d;
    end
  end
  // The bus is only ours during LOAD; the core owns it from its second WAIT cycle.
  assign SQ_DATA   = (state_q == LOAD) ? op_q : 16'hzzzz;
  assign SQ_ENABLE = (state_q == LOAD) || (state_q == WAIT);
  assign bus.IN_READY = state_q == IDLE;
  assign bus.OUT_VALID = valid_q;
  assign {bus.OUT_DATA, bus.OUT_NAN, bus.OUT_PINF, bus.OUT_NINF, bus.OUT_TIMEOUT} = res_q;
endmodule
